// File: rtl/rs_pkg.sv
// Shared constants, FSM state type and GF(8) index/vector conversions for the
// RS(7,3) encoder (primitive polynomial x^3+x+1).
package rs_pkg;

   localparam int RS_N     = 7;
   localparam int RS_K     = 3;
   localparam int RS_SYM_W = 3;
   localparam int RS_MSG_W = RS_K * RS_SYM_W;
   localparam int RS_CW_W  = RS_N * RS_SYM_W;

   // Generator coefficients in index form: 0 is zero, i is alpha^(i-1).
   localparam logic [RS_SYM_W-1:0] RS_G3 = 3'd4;
   localparam logic [RS_SYM_W-1:0] RS_G2 = 3'd1;
   localparam logic [RS_SYM_W-1:0] RS_G1 = 3'd2;
   localparam logic [RS_SYM_W-1:0] RS_G0 = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } rs_state_e;

   function automatic logic [RS_SYM_W-1:0] idx2vec(input logic [RS_SYM_W-1:0] idx);
      logic [RS_SYM_W-1:0] v;
      case (idx)
         3'd1:    v = 3'b001;
         3'd2:    v = 3'b010;
         3'd3:    v = 3'b100;
         3'd4:    v = 3'b011;
         3'd5:    v = 3'b110;
         3'd6:    v = 3'b111;
         3'd7:    v = 3'b101;
         default: v = 3'b000;
      endcase
      return v;
   endfunction

   function automatic logic [RS_SYM_W-1:0] vec2idx(input logic [RS_SYM_W-1:0] vec);
      logic [RS_SYM_W-1:0] i;
      case (vec)
         3'b001:  i = 3'd1;
         3'b010:  i = 3'd2;
         3'b100:  i = 3'd3;
         3'b011:  i = 3'd4;
         3'b110:  i = 3'd5;
         3'b111:  i = 3'd6;
         3'b101:  i = 3'd7;
         default: i = 3'd0;
      endcase
      return i;
   endfunction

endpackage

// File: rtl/rs_gf_mul.sv
// Combinational GF(8) multiplier on index-form symbols: exponents add modulo 7,
// a zero operand forces a zero product.
module rs_gf_mul
   import rs_pkg::*;
(
   input  logic [RS_SYM_W-1:0] a_i,
   input  logic [RS_SYM_W-1:0] b_i,
   output logic [RS_SYM_W-1:0] p_o
);

   logic [RS_SYM_W:0] exp_sum;

   always_comb begin
      exp_sum = {1'b0, a_i} + {1'b0, b_i} - 4'd2;
      if (exp_sum >= 4'd7) begin
         exp_sum = exp_sum - 4'd7;
      end
      if ((a_i == '0) || (b_i == '0)) begin
         p_o = '0;
      end else begin
         p_o = exp_sum[RS_SYM_W-1:0] + 3'd1;
      end
   end

endmodule

// File: rtl/rs_encoder.sv
// Systematic RS(7,3) encoder: 4-stage parity LFSR stepped one message symbol per cycle.
// Optional RS_ENC_B2B_EN lets a new message be accepted on the edge the codeword is consumed.
module rs_encoder
   import rs_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [RS_MSG_W-1:0] message,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [RS_CW_W-1:0]  codeword
);

   // Handshake: a transfer happens on a rising edge where valid and ready are both high;
   // out_valid/codeword stay frozen until out_ready is seen.
   rs_state_e                       state_q, state_d;
   logic [RS_MSG_W-1:0]             msg_q, msg_d;
   logic [3:0][RS_SYM_W-1:0]        r_q, r_d;
   logic [1:0]                      cnt_q, cnt_d;
   logic [RS_CW_W-1:0]              cw_q, cw_d;

   logic [RS_SYM_W-1:0]             cur_sym;
   logic [RS_SYM_W-1:0]             f_vec, f_idx;
   logic [RS_SYM_W-1:0]             p3, p2, p1, p0;
   logic [3:0][RS_SYM_W-1:0]        step_r;
   logic                            accept;

`ifdef RS_ENC_B2B_EN
   assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
`else
   assign in_ready = (state_q == ST_IDLE);
`endif

   assign accept    = in_valid & in_ready;
   assign out_valid = (state_q == ST_DONE);
   assign codeword  = cw_q;

   // Parity registers live in vector form so feedback addition is a plain XOR.
   always_comb begin
      case (cnt_q)
         2'd0:    cur_sym = msg_q[8:6];
         2'd1:    cur_sym = msg_q[5:3];
         default: cur_sym = msg_q[2:0];
      endcase
      f_vec = idx2vec(cur_sym) ^ r_q[3];
      f_idx = vec2idx(f_vec);
   end

   rs_gf_mul u_mul3 (.a_i(f_idx), .b_i(RS_G3), .p_o(p3));
   rs_gf_mul u_mul2 (.a_i(f_idx), .b_i(RS_G2), .p_o(p2));
   rs_gf_mul u_mul1 (.a_i(f_idx), .b_i(RS_G1), .p_o(p1));
   rs_gf_mul u_mul0 (.a_i(f_idx), .b_i(RS_G0), .p_o(p0));

   assign step_r[3] = r_q[2] ^ idx2vec(p3);
   assign step_r[2] = r_q[1] ^ idx2vec(p2);
   assign step_r[1] = r_q[0] ^ idx2vec(p1);
   assign step_r[0] = idx2vec(p0);

   always_comb begin
      state_d = state_q;
      msg_d   = msg_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      cw_d    = cw_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               msg_d   = message;
               r_d     = '0;
               cnt_d   = 2'd0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            r_d   = step_r;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd2) begin
               cw_d    = {msg_q, vec2idx(step_r[3]), vec2idx(step_r[2]),
                          vec2idx(step_r[1]), vec2idx(step_r[0])};
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // accept can only be high here in back-to-back mode, and it implies out_ready.
            if (accept) begin
               msg_d   = message;
               r_d     = '0;
               cnt_d   = 2'd0;
               state_d = ST_SHIFT;
            end else if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         msg_q   <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         cw_q    <= '0;
      end else begin
         state_q <= state_d;
         msg_q   <= msg_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         cw_q    <= cw_d;
      end
   end

endmodule

// File: tb/tb_rs_encoder.sv
// Directed and random checks for rs_encoder; works with or without RS_ENC_B2B_EN.
module tb_rs_encoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [8:0]  message;
   logic        out_valid;
   logic        out_ready;
   logic [20:0] codeword;

   int          n_total = 0;
   int          n_bad   = 0;
   int          cyc     = 0;
   int          got     = 0;
   logic [20:0] exp_q[$];

   typedef struct {
      logic [8:0]  msg;
      logic [20:0] cw;
   } vec_t;
   vec_t vecs[6];

   rs_encoder dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .message   (message),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .codeword  (codeword)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "watchdog");
   end

   // independent GF(8) model: alpha^e in vector form by repeated multiply-by-alpha
   function automatic logic [2:0] alog(input int e);
      logic [2:0] v;
      v = 3'b001;
      for (int k = 0; k < (e % 7); k++) begin
         v = {v[1:0], 1'b0} ^ (v[2] ? 3'b011 : 3'b000);
      end
      return v;
   endfunction

   function automatic logic [11:0] syndromes(input logic [20:0] cw);
      logic [11:0] s;
      logic [2:0]  acc;
      logic [2:0]  c;
      s = '0;
      for (int j = 1; j <= 4; j++) begin
         acc = '0;
         for (int i = 0; i < 7; i++) begin
            c = cw[3*i +: 3];
            if (c != 3'd0) acc = acc ^ alog(int'(c) - 1 + j * i);
         end
         s[3*(j-1) +: 3] = acc;
      end
      return s;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0o expected %0o (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_total++;
      n_bad++;
      $display("FAIL %s: got timeout expected event (cycle %0d)", name, cyc);
   endtask

   // driver tasks
   task automatic send(input logic [8:0] m, output int acc);
      in_valid = 1'b1;
      message  = m;
      acc      = -1;
      for (int i = 0; i < 40; i++) begin
         if (in_ready) begin
            @(posedge clk); #1;
            acc = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (acc < 0) timeout_fail("accept_timeout");
   endtask

   task automatic wait_cw(output logic [20:0] cw, output int lat);
      lat = -1;
      cw  = '0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            lat = i;
            cw  = codeword;
            break;
         end
      end
      if (lat < 0) timeout_fail("out_valid_timeout");
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      logic [20:0] cw;
      logic [8:0]  m;
      int          lat;
      int          a0;
      int          a1;
      int          ov_cnt;

      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      message   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_codeword", {11'd0, codeword}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);

      vecs[0] = '{msg: 9'o100, cw: 21'o1005156};
      vecs[1] = '{msg: 9'o000, cw: 21'o0000000};
      vecs[2] = '{msg: 9'o200, cw: 21'o2006267};
      vecs[3] = '{msg: 9'o001, cw: 21'o0014124};
      vecs[4] = '{msg: 9'o010, cw: 21'o0103177};
      vecs[5] = '{msg: 9'o111, cw: 21'o1111111};

      // table-driven vectors: latency, value and handshake around each
      for (int i = 0; i < 6; i++) begin
         send(vecs[i].msg, a0);
         exp_q.push_back(vecs[i].cw);
         wait_cw(cw, lat);
         check("latency", lat, 32'd3);
         check("cw_table", {11'd0, cw}, {11'd0, exp_q.pop_front()});
         check("in_ready_in_done", {31'd0, in_ready}, 32'd0);
         consume();
         check("out_valid_after_take", {31'd0, out_valid}, 32'd0);
         check("in_ready_after_take", {31'd0, in_ready}, 32'd1);
      end

      // stall: codeword held, new in_valid ignored
      send(9'o100, a0);
      wait_cw(cw, lat);
      in_valid = 1'b1;
      message  = 9'o777;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("stall_cw", {11'd0, codeword}, {11'd0, 21'o1005156});
         check("stall_out_valid", {31'd0, out_valid}, 32'd1);
         check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      consume();
      send(9'o010, a0);
      wait_cw(cw, lat);
      check("after_stall_latency", lat, 32'd3);
      check("after_stall_cw", {11'd0, cw}, {11'd0, 21'o0103177});
      consume();

      // reset during the second SHIFT cycle
      send(9'o100, a0);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
      check("midreset_codeword", {11'd0, codeword}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      check("midreset_in_ready", {31'd0, in_ready}, 32'd1);
      ov_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (out_valid) ov_cnt++;
      end
      check("midreset_discarded", ov_cnt, 32'd0);
      send(9'o200, a0);
      wait_cw(cw, lat);
      check("postreset_latency", lat, 32'd3);
      check("postreset_cw", {11'd0, cw}, {11'd0, 21'o2006267});
      consume();

      // back-to-back stream with out_ready held high
      out_ready = 1'b1;
      got = 0;
      exp_q.push_back(21'o1005156);
      exp_q.push_back(21'o2006267);
      fork
         begin
            send(9'o100, a0);
            send(9'o200, a1);
         end
         begin
            for (int i = 0; i < 60 && got < 2; i++) begin
               @(negedge clk);
               if (out_valid) begin
                  check("cw_stream", {11'd0, codeword}, {11'd0, exp_q.pop_front()});
                  got++;
               end
            end
            if (got < 2) timeout_fail("stream_timeout");
         end
      join
`ifdef RS_ENC_B2B_EN
      check("accept_spacing", a1 - a0, 32'd4);
`else
      check("accept_spacing", a1 - a0, 32'd5);
`endif
      check("exp_q_empty", exp_q.size(), 32'd0);

      // random messages against the syndrome model
      for (int i = 0; i < 512; i++) begin
         m = 9'($urandom_range(0, 511));
         send(m, a0);
         wait_cw(cw, lat);
         check("rand_systematic", {23'd0, cw[20:12]}, {23'd0, m});
         check("rand_syndrome", {20'd0, syndromes(cw)}, 32'd0);
      end
      out_ready = 1'b0;
      repeat (3) @(posedge clk);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
